chunk_head_pipe: RTL and testbench

Pipelined, parametrised successor to the DMA-pipeline chunk head. It takes one (bofs, aofs) offset token and walks config ids `beg..end-1`. For each id it emits one memory-offset vector: `global_mofs[id]` plus the shuffled, scaled b- and a-offsets. It sits between the DMA offset generator and the address/row issuer. Compared with the prior block it adds:
- a registered 3-stage datapath;
- back-to-back token acceptance;
- an explicit last-flag;
- defined empty-range behaviour;
- optional per-config masking.

---
 rtl/chunk_head_pipe.sv | 183 ++++++++++++++++++
 tb/tb_chunk_head_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_head_pipe.sv
// chunk_head_pipe: walks config ids [beg,end) per offset token and emits one scaled, shuffled
// memory-offset vector per id through ITER -> P1 -> P2. Define CHUNK_HEAD_CFG_MASK_EN to add i_cfg_mask.
module chunk_head_pipe #(
    parameter int WBW     = 16,
    parameter int N_CFG   = 4,
    parameter int VDIM    = 2,
    parameter int DIM     = 4,
    parameter int SF_BW   = 4,
    parameter int SS_BW   = 3,
    parameter int ICFG_BW = $clog2(N_CFG + 1),
    parameter int DIM_BW  = $clog2(DIM)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_abofs_rdy,
    output logic                          i_abofs_ack,
    input  logic                          i_which,
    input  logic [WBW*VDIM-1:0]           i_bofs,
    input  logic [WBW*VDIM-1:0]           i_aofs,
    input  logic [ICFG_BW-1:0]            i_beg,
    input  logic [ICFG_BW-1:0]            i_end,
    input  logic [WBW*N_CFG*DIM-1:0]      i_global_mofs,
    input  logic [DIM_BW*N_CFG*VDIM-1:0]  i_bshufs,
    input  logic [DIM_BW*N_CFG*VDIM-1:0]  i_ashufs,
    input  logic [SF_BW*N_CFG*VDIM-1:0]   i_bstrides_frac,
    input  logic [SF_BW*N_CFG*VDIM-1:0]   i_astrides_frac,
    input  logic [SS_BW*N_CFG*VDIM-1:0]   i_bstrides_shamt,
    input  logic [SS_BW*N_CFG*VDIM-1:0]   i_astrides_shamt,
`ifdef CHUNK_HEAD_CFG_MASK_EN
    input  logic [N_CFG-1:0]              i_cfg_mask,
`endif
    output logic                          o_mofs_rdy,
    input  logic                          o_mofs_ack,
    output logic                          o_which,
    output logic [WBW*DIM-1:0]            o_mofs,
    output logic [ICFG_BW-1:0]            o_id,
    output logic                          o_last,
    output logic                          o_busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [N_CFG-1:0] w_mask;
`ifdef CHUNK_HEAD_CFG_MASK_EN
    assign w_mask = i_cfg_mask;
`else
    assign w_mask = '1;
`endif

    // Returns {found, id}: lowest enabled id in [from, lim).
    function automatic logic [ICFG_BW:0] find_en(input logic [ICFG_BW-1:0] from,
                                                 input logic [ICFG_BW-1:0] lim,
                                                 input logic [N_CFG-1:0]   mask);
        logic [ICFG_BW:0] res;
        res = '0;
        for (int k = N_CFG - 1; k >= 0; k--) begin
            if (ICFG_BW'(k) >= from && ICFG_BW'(k) < lim && mask[k])
                res = {1'b1, ICFG_BW'(k)};
        end
        return res;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [ICFG_BW-1:0]   r_id, w_id_nxt, r_end;
    logic                 r_which;
    logic [WBW*VDIM-1:0]  r_bofs, r_aofs;

    logic                 r_p1_vld, r_p1_which, r_p1_last;
    logic [ICFG_BW-1:0]   r_p1_id;
    logic [WBW*VDIM-1:0]  r_p1_bs, r_p1_as, w_bs, w_as;

    logic                 r_p2_vld, r_p2_which, r_p2_last;
    logic [ICFG_BW-1:0]   r_p2_id;
    logic [WBW*DIM-1:0]   r_p2_mofs, w_sum;

    logic                 w_p1_adv, w_p2_adv, w_issue, w_last, w_accept;
    logic [ICFG_BW:0]     w_first, w_succ;

    assign w_p2_adv    = !r_p2_vld || o_mofs_ack;
    assign w_p1_adv    = !r_p1_vld || w_p2_adv;
    assign w_first     = find_en(i_beg, i_end, w_mask);
    assign w_succ      = find_en(r_id + ICFG_BW'(1), r_end, w_mask);
    assign w_issue     = (r_state == S_RUN) && w_p1_adv;
    assign w_last      = !w_succ[ICFG_BW];
    // A new token may enter in the same cycle the previous token's last id leaves ITER.
    assign i_abofs_ack = i_abofs_rdy && !i_rst && ((r_state == S_IDLE) || (w_issue && w_last));
    assign w_accept    = i_abofs_ack;

    // NOTE: defaults first so every path assigns every output -- no latch inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        if (w_issue) begin
            if (w_last) w_state_nxt = S_IDLE;
            else        w_id_nxt    = w_succ[ICFG_BW-1:0];
        end
        if (w_accept) begin
            w_state_nxt = w_first[ICFG_BW] ? S_RUN : S_IDLE;
            w_id_nxt    = w_first[ICFG_BW-1:0];
        end
    end

    always_comb begin
        w_bs = '0;
        w_as = '0;
        for (int i = 0; i < VDIM; i++) begin
            w_bs[i*WBW +: WBW] = WBW'(r_bofs[i*WBW +: WBW]
                                 * WBW'(i_bstrides_frac[(int'(r_id)*VDIM + i)*SF_BW +: SF_BW]))
                                 << i_bstrides_shamt[(int'(r_id)*VDIM + i)*SS_BW +: SS_BW];
            w_as[i*WBW +: WBW] = WBW'(r_aofs[i*WBW +: WBW]
                                 * WBW'(i_astrides_frac[(int'(r_id)*VDIM + i)*SF_BW +: SF_BW]))
                                 << i_astrides_shamt[(int'(r_id)*VDIM + i)*SS_BW +: SS_BW];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int d = 0; d < DIM; d++) begin
            w_sum[d*WBW +: WBW] = i_global_mofs[(int'(r_p1_id)*DIM + d)*WBW +: WBW];
            for (int i = 0; i < VDIM; i++) begin
                if (i_bshufs[(int'(r_p1_id)*VDIM + i)*DIM_BW +: DIM_BW] == DIM_BW'(d))
                    w_sum[d*WBW +: WBW] = w_sum[d*WBW +: WBW] + r_p1_bs[i*WBW +: WBW];
                if (i_ashufs[(int'(r_p1_id)*VDIM + i)*DIM_BW +: DIM_BW] == DIM_BW'(d))
                    w_sum[d*WBW +: WBW] = w_sum[d*WBW +: WBW] + r_p1_as[i*WBW +: WBW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_id       <= '0;
            r_p1_vld   <= 1'b0;
            r_p2_vld   <= 1'b0;
            r_p2_which <= 1'b0;
            r_p2_id    <= '0;
            r_p2_last  <= 1'b0;
            r_p2_mofs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            if (w_p1_adv) r_p1_vld <= w_issue;
            if (w_p2_adv) begin
                r_p2_vld <= r_p1_vld;
                if (r_p1_vld) begin
                    r_p2_which <= r_p1_which;
                    r_p2_id    <= r_p1_id;
                    r_p2_last  <= r_p1_last;
                    r_p2_mofs  <= w_sum;
                end
            end
        end
    end

    // NOTE: token and P1 payload registers carry no reset; their valid bits gate all use.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_which <= i_which;
            r_bofs  <= i_bofs;
            r_aofs  <= i_aofs;
            r_end   <= i_end;
        end
        if (w_issue) begin
            r_p1_id    <= r_id;
            r_p1_which <= r_which;
            r_p1_last  <= w_last;
            r_p1_bs    <= w_bs;
            r_p1_as    <= w_as;
        end
    end

    assign o_mofs_rdy = r_p2_vld;
    assign o_which    = r_p2_which;
    assign o_mofs     = r_p2_mofs;
    assign o_id       = r_p2_id;
    assign o_last     = r_p2_last;
    assign o_busy     = (r_state == S_RUN) || r_p1_vld || r_p2_vld;

    a_legal_range : assert property (@(posedge i_clk) disable iff (i_rst)
        w_accept |-> (i_beg <= i_end && i_end <= ICFG_BW'(N_CFG)));

endmodule

// File: tb/tb_chunk_head_pipe.sv
// Directed self-checking bench for chunk_head_pipe: scaling/shuffle, wrap, back-to-back tokens,
// random backpressure, empty range, mid-operation reset and (with CHUNK_HEAD_CFG_MASK_EN) masking.
module tb_chunk_head_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        abofs_rdy, abofs_ack, which;
    logic [31:0] bofs, aofs;
    logic [2:0]  beg, en;
    logic [255:0] gmofs;
    logic [15:0] bshufs, ashufs;
    logic [31:0] bfrac, afrac;
    logic [23:0] bshamt, ashamt;
`ifdef CHUNK_HEAD_CFG_MASK_EN
    logic [3:0]  cfg_mask;
`endif
    logic        mofs_rdy, mofs_ack, o_which, o_last, o_busy;
    logic [63:0] o_mofs;
    logic [2:0]  o_id;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc;
    int ack_mode = 0;
    logic rnd_ack = 1'b0;

    typedef struct { logic [63:0] mofs; logic [2:0] id; logic last; logic which; int cyc; } out_t;
    out_t q[$];
    logic [63:0] exp_m [6];
    logic [2:0]  exp_id [6];
    logic        exp_l [6], exp_w [6];

    logic        stall_prev = 1'b0;
    logic [68:0] snap;
    int          stall_viol = 0;

    chunk_head_pipe dut (
        .i_clk(clk), .i_rst(rst),
        .i_abofs_rdy(abofs_rdy), .i_abofs_ack(abofs_ack), .i_which(which),
        .i_bofs(bofs), .i_aofs(aofs), .i_beg(beg), .i_end(en),
        .i_global_mofs(gmofs), .i_bshufs(bshufs), .i_ashufs(ashufs),
        .i_bstrides_frac(bfrac), .i_astrides_frac(afrac),
        .i_bstrides_shamt(bshamt), .i_astrides_shamt(ashamt),
`ifdef CHUNK_HEAD_CFG_MASK_EN
        .i_cfg_mask(cfg_mask),
`endif
        .o_mofs_rdy(mofs_rdy), .o_mofs_ack(mofs_ack), .o_which(o_which),
        .o_mofs(o_mofs), .o_id(o_id), .o_last(o_last), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_ack <= ($urandom_range(0, 99) < 30);
    assign mofs_ack = (ack_mode == 1) || (ack_mode == 2 && rnd_ack);

    // Output collector and stall-stability watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_prev && !rst && ({o_which, o_last, o_id, o_mofs} !== snap))
            stall_viol <= stall_viol + 1;
        if (mofs_rdy && mofs_ack && !rst)
            q.push_back('{mofs: o_mofs, id: o_id, last: o_last, which: o_which, cyc: cyc});
        stall_prev <= mofs_rdy && !mofs_ack && !rst;
        snap       <= {o_which, o_last, o_id, o_mofs};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [15:0] m0, m1, m2, m3,
                            input logic [1:0] bsh0, bsh1, input logic [3:0] bf0, bf1,
                            input logic [2:0] bs0, bs1, input logic [1:0] ash0, ash1,
                            input logic [3:0] af0, af1, input logic [2:0] as0, as1);
        gmofs[(s*4+0)*16 +: 16] = m0;  gmofs[(s*4+1)*16 +: 16] = m1;
        gmofs[(s*4+2)*16 +: 16] = m2;  gmofs[(s*4+3)*16 +: 16] = m3;
        bshufs[(s*2)*2 +: 2] = bsh0;   bshufs[(s*2+1)*2 +: 2] = bsh1;
        ashufs[(s*2)*2 +: 2] = ash0;   ashufs[(s*2+1)*2 +: 2] = ash1;
        bfrac[(s*2)*4 +: 4]  = bf0;    bfrac[(s*2+1)*4 +: 4]  = bf1;
        afrac[(s*2)*4 +: 4]  = af0;    afrac[(s*2+1)*4 +: 4]  = af1;
        bshamt[(s*2)*3 +: 3] = bs0;    bshamt[(s*2+1)*3 +: 3] = bs1;
        ashamt[(s*2)*3 +: 3] = as0;    ashamt[(s*2+1)*3 +: 3] = as1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_token(input logic w, input logic [15:0] b0, b1, a0, a1,
                              input logic [2:0] bg, input logic [2:0] ed);
        logic got;
        got = 1'b0;
        which = w; bofs = {b1, b0}; aofs = {a1, a0}; beg = bg; en = ed; abofs_rdy = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (abofs_ack) begin got = 1'b1; acc_cyc = cyc; end
        end
        @(posedge clk); #1;
        abofs_rdy = 1'b0;
        check("token_acked", got, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int k = 0; k < budget && q.size() < n; k++) @(negedge clk);
        check("outputs_arrived", q.size() >= n, 1);
        idle(1);
    endtask

    task automatic check_out(input string tag, input int idx, input logic [63:0] m,
                             input logic [2:0] id, input logic l, input logic w);
        check($sformatf("%s%0d_present", tag, idx), idx < q.size(), 1);
        if (idx < q.size()) begin
            check($sformatf("%s%0d_mofs", tag, idx), q[idx].mofs, m);
            check($sformatf("%s%0d_id", tag, idx), q[idx].id, id);
            check($sformatf("%s%0d_last", tag, idx), q[idx].last, l);
            check($sformatf("%s%0d_which", tag, idx), q[idx].which, w);
        end
    endtask

    initial begin
        int acc_a, acc_b;
        rst = 1'b1; abofs_rdy = 1'b0; which = 1'b0; bofs = '0; aofs = '0; beg = '0; en = '0;
        gmofs = '0; bshufs = '0; ashufs = '0; bfrac = '0; afrac = '0; bshamt = '0; ashamt = '0;
`ifdef CHUNK_HEAD_CFG_MASK_EN
        cfg_mask = 4'b1111;
`endif
        set_slot(0, 100, 200, 300, 400, 0, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        set_slot(1, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_slot(2, 10, 20, 30, 40, 2, 3, 1, 3, 2, 0, 1, 1, 1, 2, 0, 1);
        set_slot(3, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_m[0] = {16'd400, 16'd300, 16'd205, 16'd113}; exp_id[0] = 0; exp_l[0] = 0; exp_w[0] = 1;
        exp_m[1] = {16'd7, 16'd7, 16'd7, 16'd7};         exp_id[1] = 1; exp_l[1] = 0; exp_w[1] = 1;
        exp_m[2] = {16'd55, 16'd42, 16'd21, 16'd10};     exp_id[2] = 2; exp_l[2] = 1; exp_w[2] = 1;
        exp_m[3] = {16'd400, 16'd300, 16'd204, 16'd117}; exp_id[3] = 0; exp_l[3] = 0; exp_w[3] = 0;
        exp_m[4] = {16'd7, 16'd7, 16'd7, 16'd7};         exp_id[4] = 1; exp_l[4] = 0; exp_w[4] = 0;
        exp_m[5] = {16'd52, 16'd38, 16'd38, 16'd10};     exp_id[5] = 2; exp_l[5] = 1; exp_w[5] = 0;

        idle(3);
        check("rst_rdy", mofs_rdy, 0);
        check("rst_ack", abofs_ack, 0);
        check("rst_busy", o_busy, 0);
        check("rst_mofs", o_mofs, 0);
        check("rst_id", o_id, 0);
        check("rst_last", o_last, 0);
        check("rst_which", o_which, 0);
        rst = 1'b0;
        ack_mode = 1;
        idle(1);

        // Scaling and shuffle, range [0,2)
        q.delete();
        send_token(0, 3, 5, 1, 0, 0, 2);
        acc_a = acc_cyc;
        wait_out(2, 50);
        check_out("scale", 0, {16'd400, 16'd300, 16'd205, 16'd113}, 0, 0, 0);
        check_out("scale", 1, {16'd7, 16'd7, 16'd7, 16'd7}, 1, 1, 0);
        if (q.size() > 0) check("scale_latency", q[0].cyc - acc_a, 3);
        idle(5);
        check("scale_count", q.size(), 2);
        check("scale_busy", o_busy, 0);

        // Modulo-2^WBW wrap of the accumulation
        set_slot(0, 16'hFFFF, 200, 300, 400, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        q.delete();
        send_token(1, 1, 0, 0, 0, 0, 1);
        wait_out(1, 50);
        check_out("wrap", 0, {16'd400, 16'd300, 16'd200, 16'd0}, 0, 1, 1);
        set_slot(0, 100, 200, 300, 400, 0, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        idle(3);

        // Empty range beg == end
        q.delete();
        send_token(0, 3, 5, 1, 0, 2, 2);
        check("empty_busy_next", o_busy, 0);
        idle(6);
        check("empty_count", q.size(), 0);
        check("empty_busy", o_busy, 0);

        // Back-to-back tokens with ack held high
        q.delete();
        send_token(1, 3, 5, 1, 0, 0, 3);
        acc_a = acc_cyc;
        send_token(0, 2, 4, 6, 3, 0, 3);
        acc_b = acc_cyc;
        check("b2b_second_ack_cycle", acc_b - acc_a, 3);
        wait_out(6, 60);
        for (int k = 0; k < 6; k++) check_out("b2b", k, exp_m[k], exp_id[k], exp_l[k], exp_w[k]);
        if (q.size() == 6) begin
            check("b2b_latency", q[0].cyc - acc_a, 3);
            for (int k = 1; k < 6; k++) check($sformatf("b2b_gap%0d", k), q[k].cyc - q[k-1].cyc, 1);
        end
        idle(4);

        // Random backpressure: same sequence, outputs held while stalled
        q.delete();
        ack_mode = 2;
        send_token(1, 3, 5, 1, 0, 0, 3);
        send_token(0, 2, 4, 6, 3, 0, 3);
        wait_out(6, 600);
        ack_mode = 1;
        for (int k = 0; k < 6; k++) check_out("bp", k, exp_m[k], exp_id[k], exp_l[k], exp_w[k]);
        idle(5);
        check("bp_count", q.size(), 6);
        check("bp_stable", stall_viol, 0);

`ifdef CHUNK_HEAD_CFG_MASK_EN
        cfg_mask = 4'b1010;
        q.delete();
        send_token(1, 3, 5, 1, 0, 0, 4);
        wait_out(2, 50);
        idle(5);
        check("mask_count", q.size(), 2);
        check_out("mask", 0, {16'd7, 16'd7, 16'd7, 16'd7}, 1, 0, 1);
        check_out("mask", 1, {16'd4, 16'd3, 16'd2, 16'd1}, 3, 1, 1);
        cfg_mask = 4'b0000;
        q.delete();
        send_token(0, 3, 5, 1, 0, 0, 4);
        idle(6);
        check("mask0_count", q.size(), 0);
        check("mask0_busy", o_busy, 0);
        cfg_mask = 4'b1111;
`endif

        // Reset with outputs pending
        ack_mode = 0;
        q.delete();
        send_token(1, 3, 5, 1, 0, 0, 3);
        for (int k = 0; k < 20 && !mofs_rdy; k++) idle(1);
        idle(2);
        check("midrst_pending", mofs_rdy, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_rdy", mofs_rdy, 0);
        check("midrst_busy", o_busy, 0);
        ack_mode = 1;
        idle(10);
        check("midrst_no_stale", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
